// File: rtl/mux_arb_nx1_pkg.sv
// Shared constants and helpers for the N:1 registered arbitrating multiplexer.
// Imported by the interface, the arbiter and the top level.
package mux_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    // Channel-index width that stays at least one bit wide.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_arb_nx1_if.sv
// Producer/consumer bundle for mux_arb_nx1: N input channels plus one output channel.
// The master side is the environment, the slave side is the multiplexer.
interface mux_arb_nx1_if
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int CH_W = ch_width(N);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [CH_W-1:0]    sel;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [CH_W-1:0]    out_ch;

    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );

    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );

endinterface

// File: rtl/mux_arb_nx1_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after i_ptr, wrapping modulo N.
// Produces a one-hot grant, the granted index and an any-grant flag.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N    = 4,
    localparam int CH_W = ch_width(N)
) (
    input  logic [N-1:0]    i_req,
    input  logic [CH_W-1:0] i_ptr,
    output logic [N-1:0]    o_grant,
    output logic [CH_W-1:0] o_grant_idx,
    output logic            o_any
);

    logic [CH_W-1:0] w_cand;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_cand      = '0;
        // Visit ptr+1 .. ptr+N so the last winner has lowest priority.
        for (int unsigned k = 1; k <= N; k++) begin
            w_cand = CH_W'((32'(i_ptr) + k) % N);
            if (!o_any && i_req[w_cand]) begin
                o_grant[w_cand] = 1'b1;
                o_grant_idx     = w_cand;
                o_any           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb_nx1.sv
// N-input registered multiplexer with valid/ready on every channel.
// MODE selects external steering (sel) or round-robin arbitration.
module mux_arb_nx1
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int MODE  = MODE_SEL
) (
    input logic          i_clk,
    input logic          i_rst,
    mux_arb_nx1_if.slave bus
);

    localparam int CH_W = ch_width(N);

    logic             w_load;
    logic             w_any;
    logic             w_xfer;
    logic [N-1:0]     w_grant;
    logic [CH_W-1:0]  w_idx;
    logic [WIDTH-1:0] w_data;

    logic [WIDTH-1:0] r_out_data;
    logic [CH_W-1:0]  r_out_ch;
    logic             r_out_valid;

    assign w_load       = !r_out_valid || bus.out_ready;
    assign w_xfer       = w_load && w_any && !i_rst;
    assign bus.in_ready = (w_load && !i_rst) ? w_grant : '0;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [CH_W-1:0] r_ptr;

            rr_arbiter #(.N(N)) u_arb (
                .i_req       (bus.in_valid),
                .i_ptr       (r_ptr),
                .o_grant     (w_grant),
                .o_grant_idx (w_idx),
                .o_any       (w_any)
            );

            // Reset to N-1 so channel 0 wins first.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_ptr <= CH_W'(N - 1);
                end else if (w_xfer) begin
                    r_ptr <= w_idx;
                end
            end
        end else begin : g_sel
            always_comb begin
                w_grant = '0;
                w_any   = 1'b0;
                w_idx   = bus.sel;
                if (32'(bus.sel) < N) begin
                    w_grant[bus.sel] = bus.in_valid[bus.sel];
                    w_any            = bus.in_valid[bus.sel];
                end
            end
        end
    endgenerate

    always_comb begin
        w_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (w_grant[i]) begin
                w_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else if (w_load) begin
            r_out_valid <= w_xfer;
            if (w_xfer) begin
                r_out_data <= w_data;
                r_out_ch   <= w_idx;
            end
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_ch    = r_out_ch;

endmodule

// File: tb/tb_mux_arb_nx1.sv
// Bench for mux_arb_nx1: one MODE_SEL and one MODE_RR instance against a behavioural model,
// with directed scenarios pinning literal values and a randomized producer/consumer phase.
module tb_mux_arb_nx1;

    localparam int W = 8;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_arb_nx1_if #(.WIDTH(W), .N(N)) if0 ();
    mux_arb_nx1_if #(.WIDTH(W), .N(N)) if1 ();

    mux_arb_nx1 #(.WIDTH(W), .N(N), .MODE(0)) u_sel (.i_clk(clk), .i_rst(rst), .bus(if0.slave));
    mux_arb_nx1 #(.WIDTH(W), .N(N), .MODE(1)) u_rr  (.i_clk(clk), .i_rst(rst), .bus(if1.slave));

    // Stimulus, index 0 = select-steered DUT, index 1 = round-robin DUT
    logic [N*W-1:0] s_data  [2];
    logic [N-1:0]   s_valid [2];
    logic           s_ordy  [2];
    logic [1:0]     s_sel;

    assign if0.in_data   = s_data[0];
    assign if0.in_valid  = s_valid[0];
    assign if0.out_ready = s_ordy[0];
    assign if0.sel       = s_sel;
    assign if1.in_data   = s_data[1];
    assign if1.in_valid  = s_valid[1];
    assign if1.out_ready = s_ordy[1];
    assign if1.sel       = '0;

    logic [N-1:0] d_rdy [2];
    logic [W-1:0] d_od  [2];
    logic         d_ov  [2];
    logic [1:0]   d_ch  [2];
    assign d_rdy[0] = if0.in_ready;
    assign d_od[0]  = if0.out_data;
    assign d_ov[0]  = if0.out_valid;
    assign d_ch[0]  = if0.out_ch;
    assign d_rdy[1] = if1.in_ready;
    assign d_od[1]  = if1.out_data;
    assign d_ov[1]  = if1.out_valid;
    assign d_ch[1]  = if1.out_ch;

    int vectors     = 0;
    int miscompares = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: the output register contents plus the last round-robin winner
    logic         m_valid [2];
    logic [W-1:0] m_data  [2];
    int           m_ch    [2];
    int           m_ptr;
    logic [N-1:0] xfer    [2];
    int           wcnt    [N];

    function automatic int exp_grant(input int d);
        if (d == 0) begin
            if (int'(s_sel) < N && s_valid[0][s_sel]) return int'(s_sel);
            return -1;
        end
        for (int k = 1; k <= N; k++) begin
            if (s_valid[1][(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    int           g;
    logic         ld;
    logic [N-1:0] er;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                ld = !m_valid[d] || s_ordy[d];
                g  = exp_grant(d);
                er = '0;
                if (!rst && ld && g >= 0) er[g] = 1'b1;
                chk(d == 0 ? "sel_in_ready"  : "rr_in_ready",  d_rdy[d], er);
                chk(d == 0 ? "sel_out_valid" : "rr_out_valid", d_ov[d],  m_valid[d]);
                chk(d == 0 ? "sel_out_data"  : "rr_out_data",  d_od[d],  m_data[d]);
                chk(d == 0 ? "sel_out_ch"    : "rr_out_ch",    d_ch[d],  m_ch[d]);
                xfer[d] = er;
                if (rst) begin
                    m_valid[d] = 1'b0;
                    m_data[d]  = '0;
                    m_ch[d]    = 0;
                    if (d == 1) m_ptr = N - 1;
                end else if (ld) begin
                    m_valid[d] = (g >= 0);
                    if (g >= 0) begin
                        m_data[d] = s_data[d][g*W +: W];
                        m_ch[d]   = g;
                        if (d == 1) m_ptr = g;
                    end
                end
            end
            // Fairness on the DUT's own acknowledgements: a held request loses at most N-1 times
            if (rst) begin
                for (int c = 0; c < N; c++) wcnt[c] = 0;
            end else if (|(d_rdy[1] & s_valid[1])) begin
                for (int c = 0; c < N; c++) begin
                    if (d_rdy[1][c]) wcnt[c] = 0;
                    else if (s_valid[1][c]) begin
                        wcnt[c]++;
                        chk("rr_fair_wait_ok", 32'(wcnt[c] <= N - 1), 1);
                    end else wcnt[c] = 0;
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 1'b0;
            m_data[d]  = '0;
            m_ch[d]    = 0;
            xfer[d]    = '0;
        end
        m_ptr = N - 1;
        for (int c = 0; c < N; c++) wcnt[c] = 0;

        // Reset for two edges with every channel requesting
        rst        = 1'b1;
        s_valid[0] = '1;
        s_valid[1] = '1;
        s_ordy[0]  = 1'b1;
        s_ordy[1]  = 1'b1;
        s_sel      = 2'd0;
        s_data[0]  = '0;
        s_data[1]  = {8'h13, 8'h12, 8'h11, 8'h10};
        @(posedge clk); #1 chk_en = 1'b1;
        @(negedge clk);
        chk("rst_in_ready_sel", d_rdy[0], 4'b0000);
        chk("rst_in_ready_rr",  d_rdy[1], 4'b0000);
        chk("rst_out_valid",    d_ov[1],  0);
        chk("rst_out_data",     d_od[1],  8'h00);
        chk("rst_out_ch",       d_ch[1],  0);
        @(posedge clk); #1;
        rst        = 1'b0;
        s_sel      = 2'd2;
        s_valid[0] = 4'b0100;
        s_data[0]  = {8'h00, 8'hA5, 8'h00, 8'h00};
        @(negedge clk);
        chk("rr_first_grant_ch0", d_rdy[1], 4'b0001);
        chk("sel2_ready",         d_rdy[0], 4'b0100);

        // Round-robin with all channels valid; steered DUT switches to an idle channel
        for (int e = 0; e < 8; e++) begin
            @(posedge clk); #1;
            if (e == 0) s_sel = 2'd3;
            if (e == 7) s_ordy[1] = 1'b0;
            @(negedge clk);
            chk("rr_rotation_ch",  d_ch[1], e % 4);
            chk("rr_no_bubble",    d_ov[1], 1);
            chk("rr_rotation_dat", d_od[1], 8'h10 + e % 4);
            if (e == 0) begin
                chk("sel2_out_data",  d_od[0], 8'hA5);
                chk("sel2_out_ch",    d_ch[0], 2);
                chk("sel2_out_valid", d_ov[0], 1);
            end
            if (e == 1) chk("sel3_idle_valid", d_ov[0], 0);
        end

        // Back-pressure for three edges, then release
        for (int s = 0; s < 3; s++) begin
            @(posedge clk); #1;
            if (s == 2) s_ordy[1] = 1'b1;
            @(negedge clk);
            chk("stall_out_ch",   d_ch[1], 3);
            chk("stall_out_data", d_od[1], 8'h13);
            chk("stall_in_ready", d_rdy[1], s == 2 ? 4'b0001 : 4'b0000);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("release_out_ch", d_ch[1], 0);
        for (int e = 1; e < 4; e++) begin
            @(posedge clk); #1;
            if (e == 3) s_valid[1] = 4'b1010;
            @(negedge clk);
            chk("rr_resume_ch", d_ch[1], e);
        end

        // Sparse requests after channel 3 won
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("sparse_out_ch",  d_ch[1], (k % 2 == 0) ? 1 : 3);
            chk("sparse_no_ack",  d_rdy[1] & 4'b0101, 4'b0000);
        end

        // Reset while a word is stalled
        @(posedge clk); #1 s_ordy[1] = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_stall_in_ready", d_rdy[1], 4'b0000);
        chk("rst_stall_held",     d_ov[1],  1);
        @(posedge clk); #1;
        rst        = 1'b0;
        s_valid[1] = '1;
        s_ordy[1]  = 1'b1;
        @(negedge clk);
        chk("rst_stall_dropped", d_ov[1],  0);
        chk("rst_stall_ptr",     d_rdy[1], 4'b0001);

        // Randomized producers (hold data until acknowledged) and consumers
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                s_ordy[d] = ($urandom_range(0, 9) < 7);
                for (int c = 0; c < N; c++) begin
                    if (!(s_valid[d][c] && !xfer[d][c])) begin
                        s_valid[d][c]        = ($urandom_range(0, 9) < 6);
                        s_data[d][c*W +: W]  = W'($urandom);
                    end
                end
            end
            s_sel = 2'($urandom_range(0, 3));
            rst   = ($urandom_range(0, 249) == 0);
        end
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux_arb_nx1.md
# mux_arb_nx1

Parametrised N-input, WIDTH-bit registered multiplexer with valid/ready handshaking on every input and on the output, selectable between externally steered select and round-robin arbitration. Successor to the combinational 4:1 mux: it adds width/channel-count generalisation, a registered output stage with back-pressure, and fair channel sharing. Sits between several producer channels and one shared consumer (bus, serializer, FIFO).

## Interface
- `WIDTH`, 8: data bits per channel (≥1).
- `N`, 4: number of input channels (≥2).
- `MODE`, 0: 0 = select-steered (`sel` picks the channel); 1 = round-robin arbitration (`sel` ignored).
- `CH_W`, `$clog2(N)`: channel index width (derived, not overridden).

Ports:
- `clk`  in  1  rising-edge clock, the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`  in  N  per-channel valid.
- `in_ready`  out  N  per-channel ready (combinational).
- `sel`  in  CH_W  channel select; used only when MODE=0.
- `out_data`  out  WIDTH  registered output data.
- `out_valid`  out  1  registered output valid.
- `out_ready`  in  1  consumer ready.
- `out_ch`  out  CH_W  registered index of the channel that produced `out_data`.

## Operation
- `load = !out_valid || out_ready`: the output register can accept a new word this cycle.
- Grant is one-hot and combinational, with at most one bit set:
  - MODE=0: `grant[sel] = in_valid[sel]`. If `sel ≥ N`, no grant.
  - MODE=1: the first channel with `in_valid` set, searching from `ptr+1` upward and wrapping modulo N. `ptr` is the last granted index.
- `in_ready[i] = load && grant[i] && !rst`. A transfer on channel i is `in_valid[i] && in_ready[i]`.
- On a transfer: `out_data` ← channel data, `out_ch` ← i, `out_valid` ← 1. In MODE=1, `ptr` ← i.
- If `load` is true and no transfer occurs, `out_valid` ← 0. `out_data`/`out_ch` hold their values.
- If `load` is false (`out_valid && !out_ready`), all outputs hold and every `in_ready` is 0.
- Reset values: `out_valid` 0, `out_data` 0, `out_ch` 0, `ptr` N-1 (so channel 0 has first priority after reset).
- Reset mid-operation: a held, unaccepted word is dropped. `in_ready` is 0 during any cycle with `rst` high.
- Channels not granted are never acknowledged. Producers must hold data stable while valid and not ready.
- Round-robin is fair: a continuously valid channel waits at most N-1 transfers.

## Timing
- Latency: 1 clock from input transfer to `out_valid`/`out_data`.
- Throughput: one word per clock while `out_ready` stays high.
- Combinational paths: `out_ready` → `in_ready`, `in_valid` → `in_ready`, `sel` → `in_ready`. There is no path from input to output data.
- On the same edge, a consumer accept and a new input transfer happen together (full-rate pass-through).
- `ptr` updates only on a transfer. Idle cycles and stalls leave it unchanged.
- In MODE=0, a `sel` change takes effect in the same cycle. A word already registered is unaffected.

## Structure
- Shared package `mux_pkg`: constants `MODE_SEL = 0` and `MODE_RR = 1`, plus a `clog2`-safe helper for `CH_W`.
- One sub-module, `rr_arbiter`:
  - parameter `N`; inputs `req[N]`, `ptr[CH_W]`; outputs one-hot `grant[N]`, `grant_idx[CH_W]`, `any`.
  - Purely combinational.
  - Instantiated only when `MODE == MODE_RR` (generate); MODE_SEL uses direct decode.
- Top level holds the output register, `ptr`, and the ready logic.

## Test plan
- Reset: drive `rst`=1 for 2 cycles with all `in_valid`=1 → `in_ready`=0, `out_valid`=0, `out_data`=0, `out_ch`=0. After release, MODE=1 grants channel 0 first.
- MODE=0, N=4, WIDTH=8: `sel`=2, `in_data` channel 2 = 8'hA5, `in_valid`=4'b0100, `out_ready`=1 → next cycle `out_data`=8'hA5, `out_ch`=2, `out_valid`=1. `sel`=3 with `in_valid[3]`=0 → `out_valid`=0 the following cycle.
- MODE=1: all four channels valid continuously, `out_ready`=1 → `out_ch` sequence 0,1,2,3,0,1… with one word per cycle and no bubbles.
- Back-pressure: `out_ready`=0 for 3 cycles while `out_valid`=1 → `out_data`/`out_ch` stable, `in_ready`=0, `ptr` unchanged. On `out_ready`=1, the next channel in rotation transfers on that same edge.
- Sparse requests, MODE=1: `in_valid`=4'b1010 after the last grant was channel 3 → grants 1, then 3, then 1. Channels 0 and 2 never receive `in_ready`.
- Reset mid-stall: `out_valid`=1, `out_ready`=0, assert `rst` → next cycle `out_valid`=0, `ptr`=3.
